// File: rtl/hack_pkg.sv
`default_nettype none
// ============================================================================
// Module : hack_pkg
// Purpose: Shared constants for the Hack ALU pipeline stage: datapath width
//          and the bit positions of the {zx,nx,zy,ny,f,no} control word.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package hack_pkg;

  localparam int WIDTH = 16;

  // Bit positions inside the 6-bit ctrl word.
  localparam int ZX = 5;
  localparam int NX = 4;
  localparam int ZY = 3;
  localparam int NY = 2;
  localparam int F  = 1;
  localparam int NO = 0;

endpackage : hack_pkg
`default_nettype wire

// File: rtl/And16.sv
`default_nettype none
// ============================================================================
// Module : And16
// Purpose: 16-bit bitwise AND gate, the Hack building block used on the
//          f=0 path of the ALU.
// Ports  : i_a, i_b - 16-bit operands
//          o_y      - i_a & i_b
// Rev    : 1.0  initial release
// ============================================================================
module And16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_y
);

  assign o_y = i_a & i_b;

endmodule : And16
`default_nettype wire

// File: rtl/hack_alu_core.sv
`default_nettype none
// ============================================================================
// Module : hack_alu_core
// Purpose: Combinational Hack ALU datapath, split into two halves so the
//          pipeline can register between them:
//            - operand preprocessing (zx/nx on a, zy/ny on b)
//            - function + output negation + flags (f/no on x', y')
// Ports  : i_a, i_b          - raw operands
//          i_zx,i_nx,i_zy,i_ny - preprocessing controls
//          o_x, o_y          - preprocessed operands x', y'
//          i_x, i_y          - registered preprocessed operands
//          i_f, i_no         - function select / output negate
//          o_out, o_zr, o_ng - result and its zero / negative flags
// Rev    : 1.0  initial release
// ============================================================================
module hack_alu_core
  import hack_pkg::*;
#(
  parameter int WIDTH = hack_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_zx,
  input  logic             i_nx,
  input  logic             i_zy,
  input  logic             i_ny,
  output logic [WIDTH-1:0] o_x,
  output logic [WIDTH-1:0] o_y,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic             i_f,
  input  logic             i_no,
  output logic [WIDTH-1:0] o_out,
  output logic             o_zr,
  output logic             o_ng
);

  logic [WIDTH-1:0] w_xz;
  logic [WIDTH-1:0] w_yz;
  logic [WIDTH-1:0] w_and;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_r;

  // Preprocessing: zero first, then negate.
  assign w_xz = i_zx ? '0 : i_a;
  assign w_yz = i_zy ? '0 : i_b;
  assign o_x  = i_nx ? ~w_xz : w_xz;
  assign o_y  = i_ny ? ~w_yz : w_yz;

  And16 u_and16 (
    .i_a (i_x),
    .i_b (i_y),
    .o_y (w_and)
  );

  // Carry-out is dropped; the sum wraps modulo 2^WIDTH.
  assign w_sum = i_x + i_y;
  assign w_r   = i_f ? w_sum : w_and;
  assign o_out = i_no ? ~w_r : w_r;
  assign o_zr  = (o_out == '0);
  assign o_ng  = o_out[WIDTH-1];

endmodule : hack_alu_core
`default_nettype wire

// File: rtl/hack_alu_stage.sv
`default_nettype none
// ============================================================================
// Module : hack_alu_stage
// Purpose: Two-register valid/ready pipeline around the Hack ALU.
//          S1 holds preprocessed operands and {f,no}; S2 holds the result
//          and flags. Latency 2, one bundle per cycle when not stalled.
// Ports  : clk, reset           - clock, synchronous active-high reset
//          in_valid / in_ready  - upstream handshake
//          a, b, ctrl           - operands x, y and {zx,nx,zy,ny,f,no}
//          out_valid / out_ready- downstream handshake
//          out, zr, ng          - result, (out==0), out[15]
// Rev    : 1.0  initial release
// ============================================================================
module hack_alu_stage
  import hack_pkg::*;
#(
  parameter int WIDTH = hack_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [5:0]       ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
);

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic             r_f;
  logic             r_no;

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_out;
  logic             r_zr;
  logic             r_ng;

  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  logic [WIDTH-1:0] w_out;
  logic             w_zr;
  logic             w_ng;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_advance;

  hack_alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .i_a   (a),
    .i_b   (b),
    .i_zx  (ctrl[ZX]),
    .i_nx  (ctrl[NX]),
    .i_zy  (ctrl[ZY]),
    .i_ny  (ctrl[NY]),
    .o_x   (w_x),
    .o_y   (w_y),
    .i_x   (r_x),
    .i_y   (r_y),
    .i_f   (r_f),
    .i_no  (r_no),
    .o_out (w_out),
    .o_zr  (w_zr),
    .o_ng  (w_ng)
  );

  // Room exists if either stage is empty, or S2 drains this cycle (which
  // lets S1 move forward and frees S1 for the incoming bundle).
  assign w_in_ready = !r_s1_valid || !r_s2_valid || out_ready;
  assign w_accept   = in_valid && w_in_ready;
  assign w_advance  = r_s1_valid && (!r_s2_valid || out_ready);

  // Stage 1: operands. Load on accept, else empty when contents move on.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
      r_f        <= 1'b0;
      r_no       <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_x        <= w_x;
      r_y        <= w_y;
      r_f        <= ctrl[F];
      r_no       <= ctrl[NO];
    end else if (w_advance) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Stage 2: result. Data only changes on advance, so out/zr/ng stay
  // consistent with each other and frozen while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_out      <= '0;
      r_zr       <= 1'b1;
      r_ng       <= 1'b0;
    end else if (w_advance) begin
      r_s2_valid <= 1'b1;
      r_out      <= w_out;
      r_zr       <= w_zr;
      r_ng       <= w_ng;
    end else if (out_ready) begin
      r_s2_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_s2_valid;
  assign out       = r_out;
  assign zr        = r_zr;
  assign ng        = r_ng;

endmodule : hack_alu_stage
`default_nettype wire

// File: tb/tb_hack_alu_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_hack_alu_stage
// Purpose: Directed and randomised self-checking bench for hack_alu_stage.
// Ports  : none
// Rev    : 1.0  initial release
// ============================================================================
module tb_hack_alu_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic [5:0]  ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        zr;
  logic        ng;

  int checks = 0;
  int errors = 0;

  hack_alu_stage #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ctrl      (ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .zr        (zr),
    .ng        (ng)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent reference of the Hack ALU.
  function automatic logic [15:0] ref_alu(input logic [15:0] x, input logic [15:0] y,
                                          input logic [5:0] c);
    logic [15:0] r;
    if (c[5]) x = 16'h0000;
    if (c[4]) x = ~x;
    if (c[3]) y = 16'h0000;
    if (c[2]) y = ~y;
    r = c[1] ? (x + y) : (x & y);
    if (c[0]) r = ~r;
    return r;
  endfunction

  // One isolated bundle, checked at latency 2.
  task automatic run_one(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                         input logic [5:0] tc, input logic [15:0] e);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = ta; b = tb; ctrl = tc;
    #1;
    chk({tag, "_in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF; ctrl = 6'h3F;
    #1;
    chk({tag, "_valid_early"}, out_valid, 0);
    tick();
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_out"}, out, e);
    chk({tag, "_zr"}, zr, (e == 16'h0000));
    chk({tag, "_ng"}, ng, e[15]);
    tick();
  endtask

  function automatic logic [15:0] bp_a(input int i);
    return 16'h0100 + 16'(i);
  endfunction

  logic [15:0] q[$];
  logic [15:0] exp_v;
  int          sent;
  int          rcvd;

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; ctrl = '0;
    sent = 0; rcvd = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out", out, 16'h0000);
    chk("rst_zr", zr, 1);
    chk("rst_ng", ng, 0);

    // Function vectors.
    run_one("and",    16'h00FF, 16'h0F0F, 6'b000000, 16'h000F);
    run_one("wrap1",  16'h7FFF, 16'h0001, 6'b000010, 16'h8000);
    run_one("wrap2",  16'hFFFF, 16'h0001, 6'b000010, 16'h0000);
    run_one("zero",   16'h1234, 16'h5678, 6'b101010, 16'h0000);
    run_one("one",    16'hA5A5, 16'h5A5A, 6'b111111, 16'h0001);
    run_one("minus1", 16'h0F0F, 16'hFFFF, 6'b111010, 16'hFFFF);

    // Backpressure: 4 bundles with out_ready held low.
    out_ready = 1'b0;
    ctrl = 6'b000010; b = 16'h0010;
    in_valid = 1'b1; a = bp_a(0); #1;
    chk("bp_acc0", in_ready, 1);
    tick();
    a = bp_a(1); #1;
    chk("bp_acc1", in_ready, 1);
    tick();
    a = bp_a(2); #1;
    chk("bp_full", in_ready, 0);
    chk("bp_hold_valid", out_valid, 1);
    chk("bp_hold_out", out, 16'h0110);
    tick();
    chk("bp_still_full", in_ready, 0);
    chk("bp_still_out", out, 16'h0110);
    chk("bp_still_zr", zr, 0);
    out_ready = 1'b1; #1;
    chk("bp_rel_ready", in_ready, 1);
    chk("bp_res0", out, 16'h0110);
    tick();
    a = bp_a(3); #1;
    chk("bp_res1_v", out_valid, 1);
    chk("bp_res1", out, 16'h0111);
    tick();
    in_valid = 1'b0; #1;
    chk("bp_res2_v", out_valid, 1);
    chk("bp_res2", out, 16'h0112);
    tick();
    chk("bp_res3_v", out_valid, 1);
    chk("bp_res3", out, 16'h0113);
    tick();
    chk("bp_done", out_valid, 0);

    // Reset with both stages full and stalled; reset beats the transfer.
    out_ready = 1'b0;
    in_valid = 1'b1; a = 16'h0001; b = 16'h0001; ctrl = 6'b000010;
    tick();
    a = 16'h0002;
    tick();
    a = 16'h0003; #1;
    chk("rs_full", in_ready, 0);
    out_ready = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0; #1;
    chk("rs_out_valid", out_valid, 0);
    chk("rs_in_ready", in_ready, 1);
    chk("rs_out", out, 16'h0000);
    chk("rs_zr", zr, 1);
    chk("rs_ng", ng, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rs_no_stale", out_valid, 0);
    end

    // Random traffic with a scoreboard.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a    = 16'($urandom);
      b    = 16'($urandom);
      ctrl = 6'($urandom);
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("rnd_dup", out_valid, 0);
        end else begin
          exp_v = q.pop_front();
          rcvd++;
          chk("rnd_data", {14'd0, zr, ng, out}, {14'd0, (exp_v == 16'h0000), exp_v[15], exp_v});
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_alu(a, b, ctrl));
        sent++;
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("drain_dup", out_valid, 0);
        end else begin
          exp_v = q.pop_front();
          rcvd++;
          chk("drain_data", {14'd0, zr, ng, out}, {14'd0, (exp_v == 16'h0000), exp_v[15], exp_v});
        end
      end
      tick();
    end
    chk("rnd_left", q.size(), 0);
    chk("rnd_count", rcvd, sent);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_hack_alu_stage
`default_nettype wire

// File: doc/hack_alu_stage.md
HACK_ALU_STAGE -- requirements
Module: hack_alu_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 16: datapath width; only 16 is supported.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: the upstream operand bundle is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the stage accepts a bundle this cycle.
REQ-006 SHALL have port a, input, 16 bits: operand x.
REQ-007 SHALL have port b, input, 16 bits: operand y.
REQ-008 SHALL have port ctrl, input, 6 bits: Hack ALU control {zx,nx,zy,ny,f,no}, with zx at bit 5 and no at bit 0.
REQ-009 SHALL have port out_valid, output, 1 bit: the result bundle is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-011 SHALL have port out, output, 16 bits: the ALU result.
REQ-012 SHALL have port zr, output, 1 bit: 1 when out == 0.
REQ-013 SHALL have port ng, output, 1 bit: equal to out[15].

Function
REQ-014 SHALL complete a transfer on any edge where valid and ready are both 1, on each side independently.
REQ-015 SHALL use a two-register pipeline.
- S1 captures the preprocessed operands and {f,no}.
- Preprocessing: x' = zx ? 0 : a; x' = nx ? ~x' : x'; the same for y' using zy/ny with b.
REQ-016 SHALL have S2 capture the result and flags.
- r = f ? (x' + y') mod 2^16 : (x' & y'), where the AND uses the bitwise-And16 function.
- out = no ? ~r : r.
- Carry-out is discarded; wrap-around is silent.
REQ-017 SHALL have a latency of 2: a bundle accepted at edge N is presented with out_valid=1 in the cycle after edge N+1, provided no stall occurs.
REQ-018 SHALL sustain a throughput of one bundle per cycle while out_ready=1.
REQ-019 SHALL drive in_ready = !s1_valid || !s2_valid || out_ready, a combinational function of state and out_ready only.
REQ-020 SHALL advance S1 to S2 when s1_valid && (!s2_valid || out_ready).
REQ-021 SHALL hold out, zr, ng and out_valid stable while out_valid=1 and out_ready=0.
REQ-022 SHALL keep a bundle in S1 when it is full and S2 is stalled, with in_ready=0.
REQ-023 SHALL handle a simultaneous input accept and output drain on one edge with no loss or duplication.
REQ-024 SHALL ignore a, b and ctrl when in_valid=0; out is don't-care when out_valid=0, but zr and ng SHALL stay consistent with out.

Reset
REQ-025 SHALL, on any edge with reset=1, clear s1_valid and s2_valid and set out=0, zr=1, ng=0.
REQ-026 SHALL discard in-flight bundles on reset, including a mid-stall reset, with no later emission.
REQ-027 SHALL have reset take priority over a transfer on the same edge.
REQ-028 SHALL drive in_ready=1 in the first cycle after reset deasserts.

Structure
REQ-029 SHALL place the ctrl bit-index constants (ZX=5, NX=4, ZY=3, NY=2, F=1, NO=0) and WIDTH in a shared package, hack_pkg.
REQ-030 SHALL put the combinational datapath in one sub-module, hack_alu_core.
- It instantiates And16 for the f=0 path.
- hack_alu_stage adds only the pipeline registers and the handshake.
REQ-031 SHALL contain no latches and no multicycle paths.

Verification
REQ-032 SHALL test AND: a=0x00FF, b=0x0F0F, ctrl=000000 -> out=0x000F, zr=0, ng=0, out_valid 2 cycles after accept.
REQ-033 SHALL test wrap: a=0x7FFF, b=0x0001, ctrl=000010 -> out=0x8000, ng=1; then a=0xFFFF, b=0x0001 -> out=0x0000, zr=1.
REQ-034 SHALL test constants: ctrl=101010 -> out=0x0000, zr=1; ctrl=111111 -> out=0x0001; ctrl=111010 -> out=0xFFFF, ng=1, for arbitrary a and b.
REQ-035 SHALL test backpressure:
- Stimulus: hold out_ready=0 with a stream of 4 bundles.
- Required: in_ready drops after 2 accepts and out holds the first result.
- Then release out_ready: all 4 results emerge in order, one per cycle.
REQ-036 SHALL test reset: assert reset for 1 cycle with both stages full and stalled -> next cycle out_valid=0, in_ready=1, out=0, zr=1, and no stale result ever appears.
REQ-037 SHALL test throughput: back-to-back random bundles with random out_ready -> scoreboard match against a reference model, with zero drops or duplicates.
